bar_chan_array: RTL and testbench
=================================

// Module: bar_chan_array
// PURPOSE
//  NUM_CH independent registered channels, each a valid/ready skid buffer, built by a generate loop.
//  Successor to the single-bit combinational bar: adds width, depth-2 buffering, backpressure,
//    per-channel enable and a saturating transfer counter.
//  Sits between generate-replicated producers and consumers that need full-throughput registered
//    handoff with no combinational ready path.
// PARAMETERS
//  NUM_CH  4   number of channels (>=1)
//  WIDTH   8   data bits per channel (>=1)
//  CNT_W   16  bits of each per-channel transfer counter (>=1)
// PORTS
//  clk        in   1               clock; all state on posedge
//  rst        in   1               synchronous reset, active-high
//  ch_en      in   NUM_CH          per-channel input enable
//  in_valid   in   NUM_CH          producer valid, one bit per channel
//  in_ready   out  NUM_CH          producer ready
//  in_data    in   NUM_CH*WIDTH    channel c at [c*WIDTH +: WIDTH]
//  out_valid  out  NUM_CH          consumer valid
//  out_ready  in   NUM_CH          consumer ready
//  out_data   out  NUM_CH*WIDTH    channel c at [c*WIDTH +: WIDTH]
//  cnt_clr    in   NUM_CH          per-channel counter clear
//  cnt        out  NUM_CH*CNT_W    output-transfer count, channel c at [c*CNT_W +: CNT_W]
//  busy       out  1               OR over channels of (occupancy != 0)
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset: all main/skid valids = 0, data regs = 0, cnt = 0, out_valid = 0, busy = 0.
//    in_ready = 0 while rst is high.
//  Per-channel state: main reg (drives out_*) + skid reg. Occupancy is 0, 1 or 2.
//    Skid is used only when main is full.
//  in_ready[c] = ch_en[c] & ~skid_valid[c] & ~rst.
//    Derived only from registers and ch_en, never from out_ready.
//  Accept: in_valid & in_ready. Send: out_valid & out_ready. Every transfer is one beat.
//  Transitions per channel (acc = accept, snd = send):
//    occ0: acc -> occ1, data to main. Latency in -> out_valid is 1 cycle.
//    occ1: acc & ~snd -> occ2, data to skid.
//          acc & snd  -> occ1, main <= in.
//          ~acc & snd -> occ0.
//    occ2: snd -> occ1, main <= skid (in_ready already 0, so no accept).
//  Full throughput: 1 beat/cycle sustained while out_ready stays high.
//  Order is preserved per channel. Channels never interact.
//  ch_en low: blocks new accepts immediately (same cycle). Held data still drains normally.
//  out_data is stable and out_valid is held while out_valid & ~out_ready (AXI-style hold rule).
//  in_data is sampled only on accept. X on in_data while ~in_valid must not propagate.
//  cnt: +1 on each send. Saturates at 2^CNT_W-1 (no wrap).
//    cnt_clr has priority: clear and send in the same cycle -> 0.
//  rst mid-transfer: buffered data is discarded, the counter clears,
//    and no out_valid appears on the cycle after rst.
// STRUCTURE
//  Package bar_pkg:
//    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;
//    default-parameter localparams.
//  Sub-module bar_skid_chan (WIDTH, CNT_W): one channel's skid buffer + counter.
//  Top: genvar loop instantiating NUM_CH bar_skid_chan with slice-wired ports,
//    plus the busy OR-reduce.
// TESTING
//  1. Reset, then ch0 in_valid=1 data=8'hA5, out_ready=1
//     -> out_valid[0]=1, out_data[7:0]=A5 on the next cycle; cnt[0]=1 one cycle later.
//  2. ch1 out_ready=0, push 8'h11, 8'h22, 8'h33
//     -> first two accepted, in_ready[1]=0 on the third.
//     Raise out_ready -> out 11, 22 in order; 33 accepted once in_ready returns.
//  3. All 4 channels streaming 100 beats with out_ready=1
//     -> 1 beat/cycle per channel, no drops, no cross-channel mixing (scoreboard per channel).
//  4. CNT_W=3, 9 sends on ch2 -> cnt saturates at 7.
//     cnt_clr on the same cycle as a send -> cnt=0.
//  5. ch3 holding 2 beats, ch_en[3]=0 -> in_ready[3]=0 immediately, both beats still drain.
//     rst pulse with occupancy 2 -> out_valid=0, cnt=0, busy=0 the cycle after.
//  6. Random valid/ready on all channels, 10k cycles
//     -> assertions: data stable while valid&~ready, busy matches occupancy, in_ready never
//        combinationally depends on out_ready.

Source files
------------

// File: rtl/bar_pkg.sv
// Shared types and default parameters for the bar_chan_array skid-buffer channels.
package bar_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/bar_skid_chan.sv
// One channel: two-entry valid/ready skid buffer with a saturating send counter.
module bar_skid_chan
  import bar_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_s;
  logic             snd_s;

  // Ready comes only from state and enable so no combinational path from out_ready.
  assign in_ready_o  = en_i & (occ_q != OCC_TWO) & ~rst_i;
  assign out_valid_o = (occ_q != OCC_EMPTY);
  assign out_data_o  = main_q;
  assign busy_o      = (occ_q != OCC_EMPTY);
  assign cnt_o       = cnt_q;
  assign acc_s       = in_valid_i & in_ready_o;
  assign snd_s       = out_valid_o & out_ready_i;

  // Occupancy next-state and data movement between input, skid and main.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (acc_s) begin
          occ_d  = OCC_ONE;
          main_d = in_data_i;
        end else begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (acc_s && !snd_s) begin
          occ_d  = OCC_TWO;
          skid_d = in_data_i;
        end else if (acc_s && snd_s) begin
          main_d = in_data_i;
        end else if (snd_s) begin
          occ_d = OCC_EMPTY;
        end else begin
          occ_d = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (snd_s) begin
          occ_d  = OCC_ONE;
          main_d = skid_q;
        end else begin
          occ_d = OCC_TWO;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // Saturating send counter; clear wins over a same-cycle send.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (snd_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bar_chan_array.sv
// NUM_CH independent registered skid-buffer channels plus a global busy flag.
module bar_chan_array
  import bar_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  input  logic [NUM_CH-1:0]       cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] cnt,
  output logic                    busy
);

  logic [NUM_CH-1:0] busy_ch;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bar_skid_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (ch_en[c]),
      .in_valid_i  (in_valid[c]),
      .in_ready_o  (in_ready[c]),
      .in_data_i   (in_data[c*WIDTH +: WIDTH]),
      .out_valid_o (out_valid[c]),
      .out_ready_i (out_ready[c]),
      .out_data_o  (out_data[c*WIDTH +: WIDTH]),
      .cnt_clr_i   (cnt_clr[c]),
      .cnt_o       (cnt[c*CNT_W +: CNT_W]),
      .busy_o      (busy_ch[c])
    );
  end

  assign busy = |busy_ch;

endmodule

// File: tb/tb_bar_chan_array.sv
// Self-checking bench: directed vector table, hand sequences and a queue-based reference model.
module tb_bar_chan_array;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_en, in_valid, out_ready, cnt_clr;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready, out_valid, in_ready3, out_valid3;
  logic [NUM_CH*WIDTH-1:0] out_data, out_data3;
  logic [NUM_CH*16-1:0]    cnt16;
  logic [NUM_CH*3-1:0]     cnt3;
  logic                    busy, busy3;

  bar_chan_array #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .cnt(cnt16), .busy(busy));

  bar_chan_array #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .ch_en(ch_en), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .cnt_clr(cnt_clr), .cnt(cnt3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
  endtask

  // Reference model: each channel is a FIFO of at most two beats plus a transfer tally.
  logic [WIDTH-1:0]  mq [NUM_CH][$];
  int                mcnt [NUM_CH];
  logic [NUM_CH-1:0] m_acc, m_snd, m_ir;

  task automatic model_check();
    logic any;
    any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic eir, eov;
      int   e16, e3;
      eir = !rst && ch_en[c] && (mq[c].size() < 2);
      eov = (mq[c].size() > 0);
      e16 = (mcnt[c] > 65535) ? 65535 : mcnt[c];
      e3  = (mcnt[c] > 7) ? 7 : mcnt[c];
      chk("in_ready", c, 32'(in_ready[c]), 32'(eir));
      chk("in_ready_w3", c, 32'(in_ready3[c]), 32'(eir));
      chk("out_valid", c, 32'(out_valid[c]), 32'(eov));
      chk("out_valid_w3", c, 32'(out_valid3[c]), 32'(eov));
      if (eov) begin
        chk("out_data", c, 32'(out_data[c*WIDTH +: WIDTH]), 32'(mq[c][0]));
        chk("out_data_w3", c, 32'(out_data3[c*WIDTH +: WIDTH]), 32'(mq[c][0]));
      end
      chk("cnt16", c, 32'(cnt16[c*16 +: 16]), e16);
      chk("cnt3", c, 32'(cnt3[c*3 +: 3]), e3);
      m_ir[c]  = eir;
      m_acc[c] = in_valid[c] & eir;
      m_snd[c] = eov & out_ready[c];
      any      = any | eov;
    end
    chk("busy", 0, 32'(busy), 32'(any));
    chk("busy_w3", 0, 32'(busy3), 32'(any));
  endtask

  task automatic model_update();
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        mq[c].delete();
        mcnt[c] = 0;
      end else begin
        if (m_snd[c]) void'(mq[c].pop_front());
        if (m_acc[c]) mq[c].push_back(in_data[c*WIDTH +: WIDTH]);
        if (cnt_clr[c]) mcnt[c] = 0;
        else if (m_snd[c] && mcnt[c] < 100000) mcnt[c]++;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst       = 1'b0;
    ch_en     = '1;
    in_valid  = '0;
    out_ready = '0;
    cnt_clr   = '0;
    in_data   = $urandom;
  endtask

  task automatic set_ch(input int c, input logic en, input logic iv, input logic [7:0] d, input logic ordy);
    ch_en[c]                 = en;
    in_valid[c]              = iv;
    in_data[c*WIDTH +: WIDTH] = d;
    out_ready[c]             = ordy;
  endtask

  typedef struct {
    int         ch;
    logic       rst;
    logic       en;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       clr;
    logic       e_ir;
    logic       e_ov;
    logic       chk_d;
    logic [7:0] e_od;
    int         e_cnt;
  } vec_t;

  vec_t tv [13];
  int   sent [NUM_CH];

  initial begin
    //          ch rst   en    iv    d      or    clr   ir    ov    chkd  od     cnt
    tv[0]  = '{0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    tv[1]  = '{0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tv[2]  = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 0};
    tv[3]  = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    tv[4]  = '{1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tv[5]  = '{1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 0};
    tv[6]  = '{1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 0};
    tv[7]  = '{1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 0};
    tv[8]  = '{1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1};
    tv[9]  = '{1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 2};
    tv[10] = '{1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3};
    tv[11] = '{1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3};
    tv[12] = '{1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3};

    for (int c = 0; c < NUM_CH; c++) mcnt[c] = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed vector table (single beat latency, backpressure, enable gating).
    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      rst = tv[i].rst;
      set_ch(tv[i].ch, tv[i].en, tv[i].iv, tv[i].d, tv[i].ordy);
      cnt_clr[tv[i].ch] = tv[i].clr;
      settle();
      chk("vec_in_ready", i, 32'(in_ready[tv[i].ch]), 32'(tv[i].e_ir));
      chk("vec_out_valid", i, 32'(out_valid[tv[i].ch]), 32'(tv[i].e_ov));
      if (tv[i].chk_d) chk("vec_out_data", i, 32'(out_data[tv[i].ch*WIDTH +: WIDTH]), 32'(tv[i].e_od));
      chk("vec_cnt", i, 32'(cnt16[tv[i].ch*16 +: 16]), tv[i].e_cnt);
      advance();
    end

    // All channels streaming 100 beats with out_ready held high.
    for (int c = 0; c < NUM_CH; c++) sent[c] = 0;
    for (int k = 0; k < 102; k++) begin
      idle_inputs();
      in_valid  = (k < 100) ? '1 : '0;
      out_ready = '1;
      settle();
      for (int c = 0; c < NUM_CH; c++) if (out_valid[c] && out_ready[c]) sent[c]++;
      advance();
    end
    for (int c = 0; c < NUM_CH; c++) chk("stream_beats", c, 32'(sent[c]), 32'd100);

    // Counter saturation on ch2 and clear-over-send priority.
    idle_inputs(); cnt_clr = '1; settle(); advance();
    for (int k = 0; k < 10; k++) begin
      idle_inputs(); set_ch(2, 1'b1, (k < 9), 8'(k), 1'b1); settle(); advance();
    end
    idle_inputs(); settle();
    chk("sat_cnt3", 2, 32'(cnt3[2*3 +: 3]), 32'd7);
    chk("sat_cnt16", 2, 32'(cnt16[2*16 +: 16]), 32'd9);
    advance();
    idle_inputs(); set_ch(2, 1'b1, 1'b1, 8'h5C, 1'b0); settle(); advance();
    idle_inputs(); set_ch(2, 1'b1, 1'b0, 8'h00, 1'b1); cnt_clr[2] = 1'b1; settle();
    chk("clr_send_ov", 2, 32'(out_valid[2]), 32'd1);
    advance();
    idle_inputs(); settle();
    chk("clr_prio_cnt3", 2, 32'(cnt3[2*3 +: 3]), 32'd0);
    chk("clr_prio_cnt16", 2, 32'(cnt16[2*16 +: 16]), 32'd0);
    advance();

    // ch3: enable drop blocks accepts at once; held beats still drain in order.
    idle_inputs(); set_ch(3, 1'b1, 1'b1, 8'h5A, 1'b0); settle(); advance();
    idle_inputs(); set_ch(3, 1'b0, 1'b1, 8'h6B, 1'b0); settle();
    chk("en_low_ready", 3, 32'(in_ready[3]), 32'd0);
    advance();
    idle_inputs(); set_ch(3, 1'b1, 1'b1, 8'h6B, 1'b0); settle(); advance();
    idle_inputs(); set_ch(3, 1'b0, 1'b0, 8'h00, 1'b0); settle();
    chk("hold2_ready", 3, 32'(in_ready[3]), 32'd0);
    chk("hold2_data", 3, 32'(out_data[3*WIDTH +: WIDTH]), 32'h5A);
    advance();
    idle_inputs(); set_ch(3, 1'b0, 1'b0, 8'h00, 1'b1); settle();
    chk("drain1_data", 3, 32'(out_data[3*WIDTH +: WIDTH]), 32'h5A);
    advance();
    idle_inputs(); set_ch(3, 1'b0, 1'b0, 8'h00, 1'b1); settle();
    chk("drain2_valid", 3, 32'(out_valid[3]), 32'd1);
    chk("drain2_data", 3, 32'(out_data[3*WIDTH +: WIDTH]), 32'h6B);
    advance();
    idle_inputs(); settle();
    chk("drained", 3, 32'(out_valid[3]), 32'd0);
    advance();

    // Reset with ch3 at occupancy 2 and ch0 holding data.
    for (int k = 0; k < 2; k++) begin
      idle_inputs(); set_ch(3, 1'b1, 1'b1, 8'(8'h70 + k), 1'b0); set_ch(0, 1'b1, 1'b1, 8'h0F, 1'b0);
      settle(); advance();
    end
    idle_inputs(); rst = 1'b1; in_valid = '1; settle();
    chk("rst_in_ready", 0, 32'(in_ready), 32'd0);
    advance();
    idle_inputs(); settle();
    chk("post_rst_valid", 0, 32'(out_valid), 32'd0);
    chk("post_rst_busy", 0, 32'(busy), 32'd0);
    chk("post_rst_cnt", 0, 32'(cnt16[31:0]), 32'd0);
    chk("post_rst_cnt_hi", 0, 32'(cnt16[63:32]), 32'd0);
    advance();

    // Random traffic against the model, plus out_ready independence of in_ready.
    for (int k = 0; k < 10000; k++) begin
      idle_inputs();
      rst = ($urandom_range(499) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        ch_en[c]     = ($urandom_range(7) != 0);
        in_valid[c]  = $urandom_range(1) == 1;
        out_ready[c] = $urandom_range(1) == 1;
        cnt_clr[c]   = ($urandom_range(63) == 0);
      end
      settle();
      out_ready = ~out_ready;
      #1;
      chk("ready_indep", k, 32'(in_ready), 32'(m_ir));
      out_ready = ~out_ready;
      #1;
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
